// File: rtl/paddle_if.sv
// paddle_if: player-side bundle for one paddle.
//   btn_up, btn_down : raw asynchronous push-buttons (1 = pressed)
//   bat_size         : 0 = large bat, 1 = small bat
//   fast             : base step select (0 = 1 px, 1 = 2 px)
//   center           : synchronous recentre request
//   y                : paddle centre coordinate (11 bits)
//   at_limit         : y sits on the upper or lower clamp for the current bat
// The master drives the controls and observes y/at_limit; the slave
// (paddle_ctrl) does the opposite.
interface paddle_if;
  logic        btn_up;
  logic        btn_down;
  logic        bat_size;
  logic        fast;
  logic        center;
  logic [10:0] y;
  logic        at_limit;

  modport master (
    output btn_up, btn_down, bat_size, fast, center,
    input  y, at_limit
  );

  modport slave (
    input  btn_up, btn_down, bat_size, fast, center,
    output y, at_limit
  );
endinterface

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: turns one player's raw up/down buttons into a paddle centre y.
//   clk  : clock
//   rst  : asynchronous, active-high reset
//   pad  : paddle_if.slave (buttons, bat_size, fast, center in; y, at_limit out)
// Buttons are synchronised (2 flops) and debounced, the paddle moves on a
// free-running prescaled tick, holding a direction for ACCEL_TICKS ticks
// doubles the step, and y is always saturated inside the arena for the
// current bat size.
module paddle_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int MOVE_DIV        = 100000,
  parameter int ACCEL_TICKS     = 16,
  parameter int Y_TOP           = 30,
  parameter int Y_BOT           = 450,
  parameter int Y_INIT          = 240
) (
  input logic    clk,
  input logic    rst,
  paddle_if.slave pad
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DIV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int ACC_W = $clog2(ACCEL_TICKS + 1);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(MOVE_DIV - 1);
  localparam logic [ACC_W-1:0] ACC_MAX   = ACC_W'(ACCEL_TICKS);
  localparam logic [ACC_W-1:0] ACC_ONE   = ACC_W'(1);
  localparam logic [10:0]      Y_INIT_V  = 11'(Y_INIT);
  // Clamp limits at 12 bits: centre must keep the whole bat inside the walls.
  localparam logic [11:0]      Y_MIN_LG  = 12'(Y_TOP + 29);
  localparam logic [11:0]      Y_MAX_LG  = 12'(Y_BOT - 29);
  localparam logic [11:0]      Y_MIN_SM  = 12'(Y_TOP + 19);
  localparam logic [11:0]      Y_MAX_SM  = 12'(Y_BOT - 19);

  typedef enum logic [1:0] {HOLD, SLOW, FAST} state_t;

  // ---------------------------------------------------------------
  // Synchroniser + debouncer, one lane per button (0 = up, 1 = down)
  // ---------------------------------------------------------------
  logic [1:0] raw;
  logic [1:0] deb;

  assign raw = {pad.btn_down, pad.btn_up};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic             s1_reg;
      logic             s2_reg;
      logic             deb_reg;
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_reg  <= 1'b0;
          s2_reg  <= 1'b0;
          deb_reg <= 1'b0;
          cnt_reg <= '0;
        end else begin
          s1_reg <= raw[gi];
          s2_reg <= s1_reg;
          if (s2_reg == deb_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DEB_LAST) begin
            // Level has differed for DEBOUNCE_CYCLES consecutive cycles.
            deb_reg <= s2_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
      end

      assign deb[gi] = deb_reg;
    end
  endgenerate

  // ---------------------------------------------------------------
  // Free-running movement prescaler
  // ---------------------------------------------------------------
  logic [DIV_W-1:0] presc_reg;
  logic             tick;

  assign tick = (presc_reg == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg <= '0;
    end else if (tick) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------
  // Movement FSM next-state / position computation
  // ---------------------------------------------------------------
  state_t           state_reg, state_next;
  logic [ACC_W-1:0] accel_reg, accel_next;
  logic             last_up_reg, last_up_next;
  logic [10:0]      y_reg, y_next;
  logic             at_limit_reg, at_limit_next;

  logic        dir_up, dir_dn, has_dir, same_dir;
  logic        move_en, move_double;
  logic [11:0] step, delta, y_ext, y_cand, y_min, y_max, y_sat;

  always_comb begin
    dir_up   = deb[0] & ~deb[1];
    dir_dn   = deb[1] & ~deb[0];
    has_dir  = dir_up | dir_dn;
    // A continuing run needs an active state and the remembered direction.
    same_dir = (state_reg != HOLD) && (dir_up == last_up_reg);

    state_next   = state_reg;
    accel_next   = accel_reg;
    last_up_next = last_up_reg;
    move_en      = 1'b0;
    move_double  = 1'b0;

    if (pad.center) begin
      state_next = HOLD;
      accel_next = '0;
    end else if (tick) begin
      if (!has_dir) begin
        state_next = HOLD;
        accel_next = '0;
      end else begin
        move_en      = 1'b1;
        last_up_next = dir_up;
        if (same_dir) begin
          move_double = (state_reg == FAST);
          accel_next  = (accel_reg >= ACC_MAX) ? ACC_MAX : accel_reg + ACC_ONE;
        end else begin
          accel_next = ACC_ONE;
        end
        // FAST is entered exactly when the run length reaches ACCEL_TICKS
        // and held while accel stays saturated there.
        state_next = (accel_next >= ACC_MAX) ? FAST : SLOW;
      end
    end

    step  = pad.fast ? 12'd2 : 12'd1;
    delta = move_double ? (step << 1) : step;
    y_ext = {1'b0, y_reg};

    y_cand = y_ext;
    if (move_en) begin
      if (dir_up) begin
        // Guard against wrap below zero; the clamp lifts it to y_min anyway.
        y_cand = (y_ext >= delta) ? (y_ext - delta) : 12'd0;
      end else begin
        y_cand = y_ext + delta;
      end
    end

    // Clamp runs every cycle so a bat_size change snaps y into range.
    y_min = pad.bat_size ? Y_MIN_SM : Y_MIN_LG;
    y_max = pad.bat_size ? Y_MAX_SM : Y_MAX_LG;
    if (y_cand < y_min) begin
      y_sat = y_min;
    end else if (y_cand > y_max) begin
      y_sat = y_max;
    end else begin
      y_sat = y_cand;
    end

    y_next        = pad.center ? Y_INIT_V : y_sat[10:0];
    at_limit_next = ({1'b0, y_next} == y_min) || ({1'b0, y_next} == y_max);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= HOLD;
      accel_reg    <= '0;
      last_up_reg  <= 1'b0;
      y_reg        <= Y_INIT_V;
      at_limit_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      accel_reg    <= accel_next;
      last_up_reg  <= last_up_next;
      y_reg        <= y_next;
      at_limit_reg <= at_limit_next;
    end
  end

  assign pad.y        = y_reg;
  assign pad.at_limit = at_limit_reg;

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb_paddle_ctrl: directed + randomised bench for paddle_ctrl with a
// cycle-level behavioural model (run-length based, no state encoding).
module tb_paddle_ctrl;
  localparam int DEB = 4;
  localparam int DIV = 8;
  localparam int ACC = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  paddle_if pif();

  paddle_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .MOVE_DIV(DIV),
    .ACCEL_TICKS(ACC),
    .Y_TOP(30),
    .Y_BOT(450),
    .Y_INIT(240)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pad(pif.slave)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  bit m_s1[2];
  bit m_s2[2];
  bit m_deb[2];
  int m_streak[2];
  int m_cyc;     // clock edges since reset release
  int m_y;
  int m_run;     // consecutive ticks moved in m_last direction (0 = idle)
  int m_last;    // -1 = up, +1 = down
  int m_lim;

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0; m_streak[b] = 0;
    end
    m_cyc = 0; m_y = 240; m_run = 0; m_last = 0; m_lim = 0;
  endtask

  task automatic model_edge();
    int dir, stp, cand, half, lo, hi;
    bit tick;
    bit raw[2];
    raw[0] = pif.btn_up;
    raw[1] = pif.btn_down;
    dir  = (m_deb[0] && !m_deb[1]) ? -1 : ((m_deb[1] && !m_deb[0]) ? 1 : 0);
    half = pif.bat_size ? 19 : 29;
    lo   = 30 + half;
    hi   = 450 - half;
    tick = ((m_cyc % DIV) == DIV - 1);
    if (pif.center) begin
      m_y   = 240;
      m_run = 0;
    end else begin
      cand = m_y;
      if (tick) begin
        if (dir == 0) begin
          m_run = 0;
        end else begin
          if (m_run > 0 && dir == m_last) m_run = (m_run < 1000) ? m_run + 1 : m_run;
          else m_run = 1;
          m_last = dir;
          stp  = (pif.fast ? 2 : 1) * ((m_run > ACC) ? 2 : 1);
          cand = m_y + dir * stp;
        end
      end
      m_y = (cand < lo) ? lo : ((cand > hi) ? hi : cand);
    end
    m_lim = (m_y == lo || m_y == hi) ? 1 : 0;
    for (int b = 0; b < 2; b++) begin
      if (m_s2[b] != m_deb[b]) begin
        m_streak[b]++;
        if (m_streak[b] == DEB) begin
          m_deb[b]    = m_s2[b];
          m_streak[b] = 0;
        end
      end else begin
        m_streak[b] = 0;
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
    end
    m_cyc++;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                     input bit verbose);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
    if (verbose) $display("%0t check %s observed=%0d expected=%0d", $time, tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    chk("y_model", 32'(pif.y), 32'(m_y), 1'b0);
    chk("at_limit_model", 32'(pif.at_limit), 32'(m_lim), 1'b0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int chg[$];
  task automatic collect(input int n, input int budget);
    logic [10:0] prev;
    chg.delete();
    prev = pif.y;
    for (int i = 0; i < budget && chg.size() < n; i++) begin
      step();
      if (pif.y !== prev) begin
        chg.push_back(int'(pif.y));
        prev = pif.y;
      end
    end
  endtask

  task automatic chk_seq(input string tag, input int exp[6]);
    for (int i = 0; i < 6; i++)
      chk(tag, (i < chg.size()) ? 32'(chg[i]) : 32'hFFFF_FFFF, 32'(exp[i]), 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seq_dn[6];
    int seq_up[6];
    int delta;
    logic [10:0] prev;
    seq_dn = '{241, 242, 243, 244, 246, 248};
    seq_up = '{238, 236, 234, 232, 228, 224};

    rst = 1'b1;
    pif.btn_up = 0; pif.btn_down = 0; pif.bat_size = 0; pif.fast = 0; pif.center = 0;
    model_reset();
    #12;
    chk("reset_y", 32'(pif.y), 32'd240, 1'b1);
    chk("reset_at_limit", 32'(pif.at_limit), 32'd0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // 1: idle
    run(100);
    chk("idle_y", 32'(pif.y), 32'd240, 1'b1);
    chk("idle_at_limit", 32'(pif.at_limit), 32'd0, 1'b1);

    // 2: glitch then steady down press
    pif.btn_down = 1; run(3);
    pif.btn_down = 0; run(20);
    chk("glitch_y", 32'(pif.y), 32'd240, 1'b1);
    pif.btn_down = 1;
    collect(6, 120);
    chk_seq("down_seq", seq_dn);
    pif.btn_down = 0;
    run(20);

    // 3: up, fast, large bat -> saturate at 59
    pif.center = 1; step(); pif.center = 0;
    chk("recentre_y", 32'(pif.y), 32'd240, 1'b1);
    pif.fast = 1; pif.btn_up = 1;
    collect(6, 120);
    chk_seq("up_fast_seq", seq_up);
    run(450);
    chk("top_clamp_y", 32'(pif.y), 32'd59, 1'b1);
    chk("top_clamp_at_limit", 32'(pif.at_limit), 32'd1, 1'b1);
    pif.btn_up = 0; run(40);
    chk("top_release_y", 32'(pif.y), 32'd59, 1'b1);

    // 4: bat size changes
    pif.bat_size = 1; run(2);
    chk("small_bat_y", 32'(pif.y), 32'd59, 1'b1);
    chk("small_bat_at_limit", 32'(pif.at_limit), 32'd0, 1'b1);
    pif.btn_down = 1; run(900);
    chk("bot_small_y", 32'(pif.y), 32'd431, 1'b1);
    chk("bot_small_at_limit", 32'(pif.at_limit), 32'd1, 1'b1);
    pif.btn_down = 0; run(20);
    pif.bat_size = 0; step();
    chk("snap_y", 32'(pif.y), 32'd421, 1'b1);
    chk("snap_at_limit", 32'(pif.at_limit), 32'd1, 1'b1);

    // 5: both pressed, then reversal out of FAST
    pif.fast = 0; pif.btn_up = 1; pif.btn_down = 1;
    run(90);
    chk("both_y", 32'(pif.y), 32'd421, 1'b1);
    pif.btn_down = 0; run(80);
    pif.btn_up = 0; pif.btn_down = 1;
    delta = -1;
    prev = pif.y;
    for (int i = 0; i < 60 && delta < 0; i++) begin
      step();
      if (pif.y > prev) delta = int'(pif.y) - int'(prev);
      prev = pif.y;
    end
    chk("reversal_step", 32'(delta), 32'd1, 1'b1);

    // 6: center on a tick, then async reset mid-move
    run(30);
    for (int i = 0; i < 20 && (m_cyc % DIV) != DIV - 1; i++) step();
    pif.center = 1; step(); pif.center = 0;
    chk("center_tick_y", 32'(pif.y), 32'd240, 1'b1);
    run(25);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_y", 32'(pif.y), 32'd240, 1'b1);
    chk("async_rst_at_limit", 32'(pif.at_limit), 32'd0, 1'b1);
    run(3);
    @(negedge clk);
    rst = 1'b0;
    collect(1, 40);
    chk("restart_first_y", (chg.size() > 0) ? 32'(chg[0]) : 32'hFFFF_FFFF, 32'd241, 1'b1);
    pif.btn_down = 0;

    // random phase
    for (int s = 0; s < 120; s++) begin
      pif.btn_up   = ($urandom_range(0, 2) == 0);
      pif.btn_down = ($urandom_range(0, 2) == 0);
      pif.fast     = $urandom_range(0, 1);
      pif.bat_size = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) begin
        pif.center = 1; step(); pif.center = 0;
      end
      run($urandom_range(1, 40));
    end
    $display("%0t random phase y=%0d model=%0d", $time, pif.y, m_y);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
